// File: rtl/pop_counter_pkg.sv
// Shared types and defaults for the pop counter bank: FSM encoding and default sizes.
package pop_counter_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_e;

  localparam int DEF_NUM_CH = 5;
  localparam int DEF_CNT_W  = 5;

  // Sweep pointer must reach NUM_CH itself to mark the post-sweep cycle.
  function automatic int ptr_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pop_counter_bank_if.sv
// Pop strobes, read requests and report outputs of the pop counter bank.
interface pop_counter_bank_if
  import pop_counter_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int IDX_W  = $clog2(NUM_CH)
) ();

  logic [NUM_CH-1:0] pop;
  logic              idle;
  logic              req;
  logic [IDX_W-1:0]  idx;
  logic              req_all;
  logic [CNT_W-1:0]  data_out;
  logic [IDX_W-1:0]  data_idx;
  logic              valid;
  logic              busy;
  logic [NUM_CH-1:0] overflow;

  modport master (
    output pop, idle, req, idx, req_all,
    input  data_out, data_idx, valid, busy, overflow
  );

  modport slave (
    input  pop, idle, req, idx, req_all,
    output data_out, data_idx, valid, busy, overflow
  );

endinterface

// File: rtl/pop_counter_cell.sv
// One saturating pop counter with sticky overflow; clear reloads 0, or 1 if a pop coincides.
module pop_counter_cell #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = CNT_W'(inc_i);
      ovf_d = 1'b0;
    end else if (inc_i) begin
      // A pop arriving at full scale is the lost count that flags overflow.
      if (cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/pop_counter_bank.sv
// Per-channel saturating pop counters with single-read and sweep reporting.
// Reports are registered: a request sampled at one edge is visible the following cycle.
module pop_counter_bank
  import pop_counter_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int IDX_W       = $clog2(NUM_CH),
  parameter int CLR_ON_READ = 0
) (
  input logic               clk,
  input logic               reset,
  pop_counter_bank_if.slave bus
);

  localparam int PTR_W = ptr_w(NUM_CH);

  logic [NUM_CH-1:0][CNT_W-1:0] cnt;
  logic [NUM_CH-1:0]            ovf;
  logic [NUM_CH-1:0]            clr;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] data_out_q, data_out_d;
  logic [IDX_W-1:0] data_idx_q, data_idx_d;
  logic             valid_q, valid_d;

  logic             rpt_en;
  logic [IDX_W-1:0] rpt_idx;
  logic             rpt_hit;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_cell
    pop_counter_cell #(
      .CNT_W (CNT_W)
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .inc_i (bus.pop[i]),
      .clr_i (clr[i]),
      .cnt_o (cnt[i]),
      .ovf_o (ovf[i])
    );
  end

  // Channel 0 is reported on the accepting edge so that channel j lands j cycles later;
  // the extra SWEEP cycle with ptr == NUM_CH keeps busy up through the last report.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rpt_en  = 1'b0;
    rpt_idx = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.idle && bus.req_all) begin
          state_d = S_SWEEP;
          rpt_en  = 1'b1;
          ptr_d   = PTR_W'(1);
        end else if (bus.idle && bus.req) begin
          rpt_en  = 1'b1;
          rpt_idx = bus.idx;
        end
      end
      S_SWEEP: begin
        if (ptr_q == PTR_W'(NUM_CH)) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end else begin
          rpt_en  = 1'b1;
          rpt_idx = ptr_q[IDX_W-1:0];
          ptr_d   = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  assign rpt_hit = (int'(rpt_idx) < NUM_CH);

  always_comb begin
    valid_d    = rpt_en;
    data_out_d = data_out_q;
    data_idx_d = data_idx_q;
    clr        = '0;
    if (rpt_en) begin
      data_idx_d = rpt_idx;
      data_out_d = rpt_hit ? cnt[rpt_idx] : '0;
      if ((CLR_ON_READ != 0) && rpt_hit) begin
        clr[rpt_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      data_out_q <= '0;
      data_idx_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      data_out_q <= data_out_d;
      data_idx_q <= data_idx_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.data_idx = data_idx_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = (state_q == S_SWEEP);
  assign bus.overflow = ovf;

endmodule
